// File: rtl/midi_parameter_decoder_if.sv
// Byte-stream bus from the MIDI UART receiver into the parameter decoder.
//   byte_valid : byte_data holds a received byte this cycle (no backpressure)
//   byte_data  : received MIDI byte
// Modports: master drives the stream (UART side), slave samples it (decoder).
interface midi_parameter_decoder_if;
  logic       byte_valid;
  logic [7:0] byte_data;

  modport master (
    output byte_valid,
    output byte_data
  );

  modport slave (
    input byte_valid,
    input byte_data
  );
endinterface

// File: rtl/midi_parameter_decoder.sv
// Synth global parameter types plus the MIDI parameter decoder.
//
// midi_parameter_decoder parses channel-voice MIDI messages (with running status)
// and maps Control Change numbers onto parameter fields and Program Change onto
// the waveform.
//   i_clk          : system clock
//   i_rst_n        : asynchronous active-low reset
//   bus            : byte stream from the UART receiver (slave modport)
//   o_parameters   : current parameter set, registered
//   o_wave         : current waveform, registered
//   o_param_change : one-cycle strobe naming the field just written, else PARAM_NONE
//   o_wave_change  : one-cycle strobe when o_wave is written
// Parameters: CHANNEL (accepted MIDI channel), OMNI (1 = accept every channel).
package PARAMETER;

  typedef struct packed {
    logic [6:0] volume;
    logic [6:0] unison_detune;
    logic [6:0] attack_time;
    logic [6:0] decay_time;
    logic [6:0] sustain_level;
    logic [6:0] release_time;
    logic [6:0] duty_cycle;
  } parameter_t;

  typedef enum logic [2:0] {
    SINE     = 3'd0,
    SQUARE   = 3'd1,
    TRIANGLE = 3'd2,
    SAWTOOTH = 3'd3,
    NOISE    = 3'd4,
    PIANO    = 3'd5,
    ORGAN    = 3'd6,
    VIOLIN   = 3'd7
  } wave_t;

  typedef enum logic [2:0] {
    PARAM_NONE          = 3'd0,
    PARAM_VOLUME        = 3'd1,
    PARAM_UNISON_DETUNE = 3'd2,
    PARAM_ATTACK_TIME   = 3'd3,
    PARAM_DECAY_TIME    = 3'd4,
    PARAM_SUSTAIN_LEVEL = 3'd5,
    PARAM_RELEASE_TIME  = 3'd6,
    PARAM_DUTY_CYCLE    = 3'd7
  } parameter_change_t;

  localparam parameter_t DEFAULT_PARAMETERS = '{
    volume:        7'h40,
    unison_detune: 7'h00,
    attack_time:   7'h00,
    decay_time:    7'h00,
    sustain_level: 7'h7F,
    release_time:  7'h00,
    duty_cycle:    7'h40
  };

endpackage

module midi_parameter_decoder #(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  midi_parameter_decoder_if.slave      bus,
  output PARAMETER::parameter_t        o_parameters,
  output PARAMETER::wave_t             o_wave,
  output PARAMETER::parameter_change_t o_param_change,
  output logic                         o_wave_change
);
  import PARAMETER::*;

  // StNoStatus: no running status, data bytes dropped.
  // StData1/StData2: waiting for first/second data byte of the latched message.
  typedef enum logic [1:0] {
    StNoStatus = 2'd0,
    StData1    = 2'd1,
    StData2    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KindOther    = 2'd0,
    KindCc       = 2'd1,
    KindPc       = 2'd2,
    KindPressure = 2'd3
  } kind_e;

  state_e            r_state, w_state;
  kind_e             r_kind, w_kind;
  logic              r_match, w_match;
  logic [6:0]        r_data1, w_data1;
  parameter_t        r_parameters, w_parameters;
  wave_t             r_wave, w_wave;
  parameter_change_t r_param_change, w_param_change;
  logic              r_wave_change, w_wave_change;

  logic              w_complete;
  logic [6:0]        w_value;

  always_comb begin
    w_state        = r_state;
    w_kind         = r_kind;
    w_match        = r_match;
    w_data1        = r_data1;
    w_parameters   = r_parameters;
    w_wave         = r_wave;
    w_param_change = PARAM_NONE;
    w_wave_change  = 1'b0;
    w_complete     = 1'b0;
    w_value        = bus.byte_data[6:0];

    if (bus.byte_valid) begin
      if (bus.byte_data[7:3] == 5'b11111) begin
        // Real-time bytes may interleave anywhere; they leave the parser untouched.
        w_state = r_state;
      end else if (bus.byte_data[7:4] == 4'hF) begin
        w_state = StNoStatus;
      end else if (bus.byte_data[7]) begin
        w_state = StData1;
        w_match = OMNI || (bus.byte_data[3:0] == CHANNEL);
        case (bus.byte_data[7:4])
          4'hB:    w_kind = KindCc;
          4'hC:    w_kind = KindPc;
          4'hD:    w_kind = KindPressure;
          default: w_kind = KindOther;
        endcase
      end else begin
        case (r_state)
          StData1: begin
            if (r_kind == KindPc || r_kind == KindPressure) begin
              w_complete = 1'b1;
            end else begin
              w_data1 = bus.byte_data[6:0];
              w_state = StData2;
            end
          end
          StData2: begin
            w_complete = 1'b1;
            // Running status: next data byte starts a new message of the same kind.
            w_state    = StData1;
          end
          default: w_state = StNoStatus;
        endcase
      end
    end

    if (w_complete && r_match) begin
      if (r_kind == KindCc) begin
        case (r_data1)
          7'd7: begin
            w_parameters.volume = w_value;
            w_param_change      = PARAM_VOLUME;
          end
          7'd94: begin
            w_parameters.unison_detune = w_value;
            w_param_change             = PARAM_UNISON_DETUNE;
          end
          7'd73: begin
            w_parameters.attack_time = w_value;
            w_param_change           = PARAM_ATTACK_TIME;
          end
          7'd75: begin
            w_parameters.decay_time = w_value;
            w_param_change          = PARAM_DECAY_TIME;
          end
          7'd79: begin
            w_parameters.sustain_level = w_value;
            w_param_change             = PARAM_SUSTAIN_LEVEL;
          end
          7'd72: begin
            w_parameters.release_time = w_value;
            w_param_change            = PARAM_RELEASE_TIME;
          end
          7'd77: begin
            w_parameters.duty_cycle = w_value;
            w_param_change          = PARAM_DUTY_CYCLE;
          end
          default: w_param_change = PARAM_NONE;
        endcase
      end else if (r_kind == KindPc) begin
        w_wave        = wave_t'(bus.byte_data[2:0]);
        w_wave_change = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= StNoStatus;
      r_kind         <= KindOther;
      r_match        <= 1'b0;
      r_data1        <= 7'd0;
      r_parameters   <= DEFAULT_PARAMETERS;
      r_wave         <= SINE;
      r_param_change <= PARAM_NONE;
      r_wave_change  <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_kind         <= w_kind;
      r_match        <= w_match;
      r_data1        <= w_data1;
      r_parameters   <= w_parameters;
      r_wave         <= w_wave;
      r_param_change <= w_param_change;
      r_wave_change  <= w_wave_change;
    end
  end

  assign o_parameters   = r_parameters;
  assign o_wave         = r_wave;
  assign o_param_change = r_param_change;
  assign o_wave_change  = r_wave_change;

endmodule

// File: tb/tb_midi_parameter_decoder.sv
// Randomized bench for midi_parameter_decoder: three instances (channel 0, channel 2,
// omni) share one byte stream and are compared every cycle against a message-level
// reference model.
module tb_midi_parameter_decoder;
  import PARAMETER::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  midi_parameter_decoder_if bus ();

  parameter_t        par[3];
  wave_t             wv[3];
  parameter_change_t pc[3];
  logic              wc[3];

  midi_parameter_decoder #(.CHANNEL(4'd0), .OMNI(1'b0)) u_dut_ch0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .o_parameters(par[0]), .o_wave(wv[0]), .o_param_change(pc[0]), .o_wave_change(wc[0])
  );
  midi_parameter_decoder #(.CHANNEL(4'd2), .OMNI(1'b0)) u_dut_ch2 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .o_parameters(par[1]), .o_wave(wv[1]), .o_param_change(pc[1]), .o_wave_change(wc[1])
  );
  midi_parameter_decoder #(.CHANNEL(4'd9), .OMNI(1'b1)) u_dut_omni (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .o_parameters(par[2]), .o_wave(wv[2]), .o_param_change(pc[2]), .o_wave_change(wc[2])
  );

  int chan_cfg[3] = '{0, 2, 9};
  bit omni_cfg[3] = '{1'b0, 1'b0, 1'b1};

  // Field order: volume, detune, attack, decay, sustain, release, duty.
  int                cc_num[7]  = '{7, 94, 73, 75, 79, 72, 77};
  parameter_change_t cc_code[7] = '{PARAM_VOLUME, PARAM_UNISON_DETUNE, PARAM_ATTACK_TIME,
                                    PARAM_DECAY_TIME, PARAM_SUSTAIN_LEVEL, PARAM_RELEASE_TIME,
                                    PARAM_DUTY_CYCLE};
  int                dflt[7]    = '{64, 0, 0, 0, 127, 0, 64};

  int m_par[3][7];
  int m_wave[3];
  int m_pc[3];
  int m_wc[3];
  int rs;      // running status byte, -1 when none
  int q[$];    // data bytes collected for the current message

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 7; k++) m_par[i][k] = dflt[k];
      m_wave[i] = 0;
      m_pc[i]   = 0;
      m_wc[i]   = 0;
    end
    rs = -1;
    q.delete();
  endfunction

  function automatic void model_apply();
    int hi;
    int ch;
    hi = rs / 16;
    ch = rs % 16;
    for (int i = 0; i < 3; i++) begin
      if (omni_cfg[i] || ch == chan_cfg[i]) begin
        if (hi == 11) begin
          for (int k = 0; k < 7; k++) begin
            if (q[0] == cc_num[k]) begin
              m_par[i][k] = q[1];
              m_pc[i]     = int'(cc_code[k]);
            end
          end
        end else if (hi == 12) begin
          m_wave[i] = q[0] % 8;
          m_wc[i]   = 1;
        end
      end
    end
  endfunction

  function automatic void model_byte(input bit v, input int b);
    int need;
    for (int i = 0; i < 3; i++) begin
      m_pc[i] = 0;
      m_wc[i] = 0;
    end
    if (!v) return;
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin
      rs = -1;
      q.delete();
    end else if (b >= 'h80) begin
      rs = b;
      q.delete();
    end else if (rs >= 0) begin
      q.push_back(b);
      need = (rs / 16 == 12 || rs / 16 == 13) ? 1 : 2;
      if (q.size() == need) begin
        model_apply();
        q.delete();
      end
    end
  endfunction

  function automatic logic [48:0] model_pack(input int i);
    logic [48:0] r;
    r = '0;
    for (int k = 0; k < 7; k++) r = {r[41:0], 7'(m_par[i][k])};
    return r;
  endfunction

  task automatic check_all(input string tag);
    logic [48:0] p;
    logic [2:0]  w;
    logic [2:0]  c;
    for (int i = 0; i < 3; i++) begin
      p = par[i];
      w = wv[i];
      c = pc[i];
      check_eq($sformatf("%s.d%0d.params", tag, i), 64'(p), 64'(model_pack(i)));
      check_eq($sformatf("%s.d%0d.wave", tag, i), 64'(w), 64'(m_wave[i]));
      check_eq($sformatf("%s.d%0d.param_change", tag, i), 64'(c), 64'(m_pc[i]));
      check_eq($sformatf("%s.d%0d.wave_change", tag, i), 64'(wc[i]), 64'(m_wc[i]));
    end
  endtask

  task automatic send(input bit v, input logic [7:0] b, input string tag);
    @(negedge clk);
    bus.byte_valid = v;
    bus.byte_data  = b;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    model_byte(v, int'(b));
    check_all(tag);
  endtask

  task automatic send_list(input int bytes[$], input string tag);
    foreach (bytes[j]) send(1'b1, 8'(bytes[j]), tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    int hi;
    int hi_tab[10] = '{8, 9, 10, 11, 11, 11, 12, 12, 13, 14};
    int ch_tab[4]  = '{0, 2, 9, 15};
    logic [7:0] b;

    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 8'h00, "idle");

    // CC with running status
    send_list('{'hB0, 'h07, 'h10}, "cc_vol");
    check_eq("cc_vol.explicit", 64'(par[0].volume), 64'h10);
    check_eq("cc_vol.strobe", 64'(pc[0]), 64'(PARAM_VOLUME));
    send_list('{'h49, 'h22}, "cc_att");
    check_eq("cc_att.explicit", 64'(par[0].attack_time), 64'h22);
    send(1'b0, 8'h00, "strobe_drop");

    // Real-time interleave, then abort by a new status byte
    send_list('{'hB0, 'h48, 'hF8, 'h05}, "rt_rel");
    check_eq("rt_rel.explicit", 64'(par[0].release_time), 64'h05);
    send_list('{'hB0, 'h4B, 'h90, 'h3C, 'h40}, "abort");
    check_eq("abort.decay", 64'(par[0].decay_time), 64'h00);

    // Channel filter
    send_list('{'hB3, 'h07, 'h55}, "ch3");
    send_list('{'hB2, 'h07, 'h55}, "ch2");
    check_eq("ch2.explicit", 64'(par[1].volume), 64'h55);
    send_list('{'hBF, 'h4D, 'h11}, "omni");
    check_eq("omni.explicit", 64'(par[2].duty_cycle), 64'h11);

    // Program change back to back, then SysEx
    send_list('{'hC0, 'h0A}, "pc1");
    check_eq("pc1.explicit", 64'(wv[0]), 64'(TRIANGLE));
    send(1'b1, 8'h07, "pc2");
    check_eq("pc2.explicit", 64'(wv[0]), 64'(VIOLIN));
    check_eq("pc2.strobe", 64'(wc[0]), 64'd1);
    send_list('{'hF0, 'h01, 'h02, 'hF7, 'h03}, "sysex");

    // Reset mid-message
    send_list('{'hB0, 'h07}, "pre_rst");
    do_reset("mid_rst");
    send(1'b1, 8'h7F, "post_rst");
    check_eq("post_rst.explicit", 64'(par[0].volume), 64'h40);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        send(1'b0, 8'(8'($urandom)), "rnd_idle");
      end else if (r < 15) begin
        send(1'b1, 8'(8'hF8 + 8'($urandom_range(0, 7))), "rnd_rt");
      end else if (r < 18) begin
        send(1'b1, 8'(8'hF0 + 8'($urandom_range(0, 7))), "rnd_sys");
      end else if (r < 38) begin
        hi = hi_tab[$urandom_range(0, 9)];
        b  = 8'(hi * 16 + ch_tab[$urandom_range(0, 3)]);
        send(1'b1, b, "rnd_status");
      end else begin
        if (q.size() == 0 && rs >= 0 && rs / 16 == 11 && $urandom_range(0, 9) < 6)
          b = 8'(cc_num[$urandom_range(0, 6)]);
        else
          b = 8'($urandom_range(0, 127));
        send(1'b1, b, "rnd_data");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
